// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the shared memory crossbar and mem_arb.
// The master side drives requests and crossbar read data; the slave side is the arbiter.
interface mem_arb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic                  i_p0_req;
  logic [ADDR_W-1:0]     i_p0_addr;
  logic [DATA_W-1:0]     i_p0_data;
  logic [DATA_W/8-1:0]   i_p0_mask;
  logic                  i_p0_wren;
  logic                  o_p0_gnt;
  logic                  o_p0_rvalid;
  logic [DATA_W-1:0]     o_p0_rdata;

  logic                  i_p1_req;
  logic [ADDR_W-1:0]     i_p1_addr;
  logic [DATA_W-1:0]     i_p1_data;
  logic [DATA_W/8-1:0]   i_p1_mask;
  logic                  i_p1_wren;
  logic                  o_p1_gnt;
  logic                  o_p1_rvalid;
  logic [DATA_W-1:0]     o_p1_rdata;

  logic                  o_mem_en;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_data;
  logic [DATA_W/8-1:0]   o_mem_mask;
  logic                  o_mem_wren;
  logic [DATA_W-1:0]     i_mem_data;

  modport master (
    output i_p0_req, i_p0_addr, i_p0_data, i_p0_mask, i_p0_wren,
    output i_p1_req, i_p1_addr, i_p1_data, i_p1_mask, i_p1_wren,
    output i_mem_data,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    input  o_mem_en, o_mem_addr, o_mem_data, o_mem_mask, o_mem_wren
  );

  modport slave (
    input  i_p0_req, i_p0_addr, i_p0_data, i_p0_mask, i_p0_wren,
    input  i_p1_req, i_p1_addr, i_p1_data, i_p1_mask, i_p1_wren,
    input  i_mem_data,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    output o_mem_en, o_mem_addr, o_mem_data, o_mem_mask, o_mem_wren
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter onto one memory crossbar port. Grants are zero-cycle;
// read data is steered back to its owner one cycle after the grant.
module mem_arb #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input logic      i_clk,
  input logic      i_rst_n,
  mem_arb_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  logic gnt0_s;
  logic gnt1_s;
  logic sel_wren_s;
  logic last_r;       // 1: port 1 was granted most recently
  logic last_nxt_s;
  logic pend_r;       // a read response arrives this cycle
  logic pend_nxt_s;
  logic owner_r;      // port that owns the pending response
  logic owner_nxt_s;

  // Arbitration: a lone requester wins, contention goes to the port not granted last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!i_rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({bus.i_p1_req, bus.i_p0_req})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          gnt0_s = last_r;
          gnt1_s = ~last_r;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state: remember the winner and whether a read response is owed next cycle.
  always_comb begin
    last_nxt_s  = last_r;
    pend_nxt_s  = 1'b0;
    owner_nxt_s = owner_r;
    sel_wren_s  = 1'b0;
    if (gnt1_s) begin
      sel_wren_s = bus.i_p1_wren;
    end else begin
      sel_wren_s = bus.i_p0_wren;
    end
    if (gnt0_s || gnt1_s) begin
      last_nxt_s  = gnt1_s;
      pend_nxt_s  = ~sel_wren_s;
      owner_nxt_s = gnt1_s;
    end else begin
      last_nxt_s  = last_r;
      pend_nxt_s  = 1'b0;
      owner_nxt_s = owner_r;
    end
  end

  // State registers; reset leaves port 1 as last winner so port 0 takes the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_r  <= 1'b1;
      pend_r  <= 1'b0;
      owner_r <= 1'b0;
    end else begin
      last_r  <= last_nxt_s;
      pend_r  <= pend_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Outputs: request mux toward memory and response steering back to the owner.
  always_comb begin
    bus.o_p0_gnt    = gnt0_s;
    bus.o_p1_gnt    = gnt1_s;
    bus.o_mem_en    = gnt0_s | gnt1_s;
    bus.o_mem_addr  = {ADDR_W{1'b0}};
    bus.o_mem_data  = {DATA_W{1'b0}};
    bus.o_mem_mask  = {MASK_W{1'b0}};
    bus.o_mem_wren  = 1'b0;
    bus.o_p0_rvalid = 1'b0;
    bus.o_p1_rvalid = 1'b0;
    bus.o_p0_rdata  = {DATA_W{1'b0}};
    bus.o_p1_rdata  = {DATA_W{1'b0}};
    if (gnt1_s) begin
      bus.o_mem_addr = bus.i_p1_addr;
      bus.o_mem_data = bus.i_p1_data;
      bus.o_mem_mask = bus.i_p1_mask;
      bus.o_mem_wren = bus.i_p1_wren;
    end else if (gnt0_s) begin
      bus.o_mem_addr = bus.i_p0_addr;
      bus.o_mem_data = bus.i_p0_data;
      bus.o_mem_mask = bus.i_p0_mask;
      bus.o_mem_wren = bus.i_p0_wren;
    end else begin
      bus.o_mem_wren = 1'b0;
    end
    if (pend_r && owner_r) begin
      bus.o_p1_rvalid = 1'b1;
      bus.o_p1_rdata  = bus.i_mem_data;
    end else if (pend_r) begin
      bus.o_p0_rvalid = 1'b1;
      bus.o_p0_rdata  = bus.i_mem_data;
    end else begin
      bus.o_p0_rvalid = 1'b0;
    end
  end
endmodule
